// File: rtl/stack_pkg.sv
// Shared types for the stack frame sequencer: operation codes and FSM states.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH     = 2'd0,
    OP_POP      = 2'd1,
    OP_POP_SKIP = 2'd2,
    OP_POP_DATA = 2'd3
  } stack_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StPush,
    StPopRd,
    StPopCap,
    StInc,
    StImmWr,
    StDone
  } stack_state_t;

endpackage

// File: rtl/stack_frame_engine.sv
// Multi-cycle CALL/RET frame mover between the core PC and nibble RAM via SP.
// All outputs are registered one cycle behind the state that produces them.
module stack_frame_engine
  import stack_pkg::*;
#(
  parameter int unsigned PC_WIDTH      = 13,
  parameter int unsigned FRAME_NIBBLES = 3,
  parameter int unsigned IMM_NIBBLES   = 2,
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned SP_WIDTH      = 8,
  parameter int unsigned X_LOW_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  stack_op_t                op,
  input  logic [PC_WIDTH-1:0]      pc_in,
  input  logic [SP_WIDTH-1:0]      sp_in,
  input  logic [ADDR_WIDTH-1:0]    x_in,
  input  logic [4*IMM_NIBBLES-1:0] imm,
  output logic                     busy,
  output logic                     done,
  output logic [PC_WIDTH-1:0]      pc_out,
  output logic [SP_WIDTH-1:0]      sp_out,
  output logic [ADDR_WIDTH-1:0]    x_out,
  output logic                     sp_wrap,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [3:0]               mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [3:0]               mem_rdata
);

  localparam int unsigned StkW   = 4 * FRAME_NIBBLES;
  localparam int unsigned CntMax = (FRAME_NIBBLES > IMM_NIBBLES) ? FRAME_NIBBLES : IMM_NIBBLES;
  localparam int unsigned IdxW   = $clog2(CntMax + 1);
  localparam logic [ADDR_WIDTH-1:0] XLowMask =
      {ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - X_LOW_WIDTH);

  stack_state_t                 state_q, state_d;
  stack_op_t                    op_q, op_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic [SP_WIDTH-1:0]          sp_q, sp_d;
  logic [ADDR_WIDTH-1:0]        x_q, x_d;
  logic [4*IMM_NIBBLES-1:0]     imm_q, imm_d;
  logic                         wrap_q, wrap_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
  logic [3:0]                   mem_wdata_q, mem_wdata_d;
  logic                         mem_we_q, mem_we_d;
  logic                         mem_re_q, mem_re_d;
  logic                         rd_pend_q, rd_pend_d;

  logic                         last_frame;
  logic                         last_imm;
  logic [IdxW-1:0]              push_nib;
  logic [SP_WIDTH-1:0]          sp_dec;
  logic [SP_WIDTH-1:0]          sp_inc;

  assign last_frame = (idx_q == IdxW'(FRAME_NIBBLES - 1));
  assign last_imm   = (idx_q == IdxW'(IMM_NIBBLES - 1));
  assign push_nib   = IdxW'(FRAME_NIBBLES - 1) - idx_q;
  assign sp_dec     = sp_q - 1'b1;
  assign sp_inc     = sp_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    x_d         = x_q;
    imm_d       = imm_q;
    wrap_d      = wrap_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rd_pend_d   = mem_re_q;

    // Read data arrives one cycle after the strobe; shift it in from the top so that
    // the first nibble read ends up as nibble 0. The INC step rides on the last capture.
    if (rd_pend_q) begin
      pc_d[StkW-1:0] = StkW'({mem_rdata, pc_q[StkW-1:0]} >> 4) + StkW'(state_q == StInc);
    end

    unique case (state_q)
      StIdle: begin
        if (start && !done_q) begin
          op_d    = op;
          pc_d    = pc_in;
          sp_d    = sp_in;
          x_d     = x_in;
          imm_d   = imm;
          wrap_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = (op == OP_PUSH) ? StPush : StPopRd;
        end
      end
      StPush: begin
        busy_d      = 1'b1;
        mem_addr_d  = ADDR_WIDTH'(sp_dec);
        mem_wdata_d = 4'(pc_q >> {push_nib, 2'b00});
        mem_we_d    = 1'b1;
        sp_d        = sp_dec;
        if (sp_q == '0) wrap_d = 1'b1;
        idx_d       = idx_q + 1'b1;
        if (last_frame) state_d = StDone;
      end
      StPopRd: begin
        busy_d     = 1'b1;
        mem_addr_d = ADDR_WIDTH'(sp_q);
        mem_re_d   = 1'b1;
        sp_d       = sp_inc;
        if (sp_q == '1) wrap_d = 1'b1;
        idx_d      = idx_q + 1'b1;
        if (last_frame) state_d = StPopCap;
      end
      StPopCap: begin
        busy_d = 1'b1;
        idx_d  = '0;
        case (op_q)
          OP_POP_SKIP: state_d = StInc;
          OP_POP_DATA: state_d = StImmWr;
          default:     state_d = StDone;
        endcase
      end
      StInc: begin
        busy_d  = 1'b1;
        state_d = StDone;
      end
      StImmWr: begin
        busy_d      = 1'b1;
        mem_addr_d  = x_q;
        mem_wdata_d = 4'(imm_q >> {idx_q, 2'b00});
        mem_we_d    = 1'b1;
        // Only the low X bits count; the page above them is held.
        x_d         = (x_q & ~XLowMask) | ((x_q + 1'b1) & XLowMask);
        idx_d       = idx_q + 1'b1;
        if (last_imm) state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= OP_PUSH;
      idx_q       <= '0;
      pc_q        <= '0;
      sp_q        <= '0;
      x_q         <= '0;
      imm_q       <= '0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      x_q         <= x_d;
      imm_q       <= imm_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pc_out    = pc_q;
  assign sp_out    = sp_q;
  assign x_out     = x_q;
  assign sp_wrap   = wrap_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_stack_frame_engine.sv
// Bench for stack_frame_engine: default instance plus a 4-nibble-frame, 16-bit-PC instance.
module tb_stack_frame_engine;
  import stack_pkg::*;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [3:0]  data;
  } xact_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  stack_op_t   op;
  logic [12:0] pc_a;
  logic [15:0] pc_b;
  logic [7:0]  sp_in;
  logic [11:0] x_in;
  logic [7:0]  imm;

  logic        a_busy, a_done, a_wrap, a_we, a_re;
  logic [12:0] a_pc;
  logic [7:0]  a_sp;
  logic [11:0] a_x, a_addr;
  logic [3:0]  a_wdata, a_rdata;

  logic        b_busy, b_done, b_wrap, b_we, b_re;
  logic [15:0] b_pc;
  logic [7:0]  b_sp;
  logic [11:0] b_x, b_addr;
  logic [3:0]  b_wdata, b_rdata;

  logic [3:0] ram_a [4096];
  logic [3:0] ram_b [4096];

  stack_frame_engine u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .op(op), .pc_in(pc_a), .sp_in(sp_in),
    .x_in(x_in), .imm(imm), .busy(a_busy), .done(a_done), .pc_out(a_pc), .sp_out(a_sp),
    .x_out(a_x), .sp_wrap(a_wrap), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we),
    .mem_re(a_re), .mem_rdata(a_rdata)
  );

  stack_frame_engine #(
    .PC_WIDTH(16), .FRAME_NIBBLES(4), .IMM_NIBBLES(2), .ADDR_WIDTH(12), .SP_WIDTH(8),
    .X_LOW_WIDTH(8)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op(op), .pc_in(pc_b), .sp_in(sp_in),
    .x_in(x_in), .imm(imm), .busy(b_busy), .done(b_done), .pc_out(b_pc), .sp_out(b_sp),
    .x_out(b_x), .sp_wrap(b_wrap), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we),
    .mem_re(b_re), .mem_rdata(b_rdata)
  );

  // Nibble RAMs with one-cycle read latency
  always @(posedge clk) begin
    if (a_we) ram_a[a_addr] <= a_wdata;
    if (a_re) a_rdata <= ram_a[a_addr];
    if (b_we) ram_b[b_addr] <= b_wdata;
    if (b_re) b_rdata <= ram_b[b_addr];
  end

  bit          sel;
  logic        o_busy, o_done, o_wrap, o_we, o_re;
  logic [15:0] o_pc;
  logic [7:0]  o_sp;
  logic [11:0] o_x, o_addr;
  logic [3:0]  o_wdata;

  always_comb begin
    if (sel) begin
      o_busy = b_busy; o_done = b_done; o_wrap = b_wrap; o_we = b_we; o_re = b_re;
      o_pc = b_pc; o_sp = b_sp; o_x = b_x; o_addr = b_addr; o_wdata = b_wdata;
    end else begin
      o_busy = a_busy; o_done = a_done; o_wrap = a_wrap; o_we = a_we; o_re = a_re;
      o_pc = {3'b000, a_pc}; o_sp = a_sp; o_x = a_x; o_addr = a_addr; o_wdata = a_wdata;
    end
  end

  int          total = 0;
  int          bad = 0;
  int          k = 0;
  int          lat = 0;
  int          done_edge = -1;
  bit          active = 1'b0;
  xact_t       exp_q[$];
  logic [15:0] exp_pc;
  logic [7:0]  exp_sp;
  logic [11:0] exp_x;
  logic        exp_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model while an operation is in flight
  always @(negedge clk) begin
    xact_t t;
    if (active) begin
      check("busy", o_busy, k < lat);
      check("done", o_done, k == lat);
      check("we_and_re", o_we & o_re, 0);
      if (o_done) done_edge = k;
      if (o_we || o_re) begin
        if (exp_q.size() == 0) begin
          check("unexpected_mem", {o_we, o_re}, 0);
        end else begin
          t = exp_q.pop_front();
          check("mem_we", o_we, t.we);
          check("mem_addr", o_addr, t.addr);
          if (t.we) check("mem_wdata", o_wdata, t.data);
        end
      end
      if (k == lat) begin
        check("pc_out", o_pc, exp_pc);
        check("sp_out", o_sp, exp_sp);
        check("x_out", o_x, exp_x);
        check("sp_wrap", o_wrap, exp_wrap);
        check("missing_mem", exp_q.size(), 0);
        active = 1'b0;
      end
      k++;
    end
  end

  // Model computed from the frame rules, then drive one operation and wait for it
  task automatic run(input bit s, input stack_op_t o, input logic [15:0] pc,
                     input logic [7:0] sp, input logic [11:0] x, input logic [7:0] im,
                     input int pulse_at);
    int n, pci, spi, xi, stk, bank, mask;
    n    = s ? 4 : 3;
    pci  = int'(pc);
    spi  = int'(sp);
    xi   = int'(x);
    mask = (1 << (4 * n)) - 1;
    exp_q.delete();
    exp_x    = x;
    exp_wrap = 1'b0;
    if (o == OP_PUSH) begin
      for (int i = 1; i <= n; i++)
        exp_q.push_back('{1'b1, 12'((spi - i) & 255), 4'((pci >> (4 * (n - i))) & 15)});
      exp_sp   = 8'((spi - n) & 255);
      exp_wrap = (spi < n);
      exp_pc   = pc;
      lat      = n + 1;
    end else begin
      stk = 0;
      for (int i = 0; i < n; i++) begin
        int a;
        a = (spi + i) & 255;
        exp_q.push_back('{1'b0, 12'(a), 4'h0});
        stk = stk | (int'(s ? ram_b[12'(a)] : ram_a[12'(a)]) << (4 * i));
      end
      exp_sp   = 8'((spi + n) & 255);
      exp_wrap = ((spi + n) > 255);
      lat      = n + 2;
      if (o == OP_POP_SKIP) begin
        stk = (stk + 1) & mask;
        lat = lat + 1;
      end
      bank   = pci >> (4 * n);
      exp_pc = 16'((bank << (4 * n)) | stk);
      if (o == OP_POP_DATA) begin
        for (int j = 0; j < 2; j++)
          exp_q.push_back('{1'b1, 12'((xi & 'hF00) | ((xi + j) & 'hFF)),
                            4'((int'(im) >> (4 * j)) & 15)});
        exp_x = 12'((xi & 'hF00) | ((xi + 2) & 'hFF));
        lat   = lat + 2;
      end
    end

    @(negedge clk);
    sel   = s;
    op    = o;
    sp_in = sp;
    x_in  = x;
    imm   = im;
    pc_a  = pc[12:0];
    pc_b  = pc;
    if (s) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    k         = 0;
    done_edge = -1;
    active    = 1'b1;
    if (pulse_at > 0) begin
      repeat (pulse_at) @(negedge clk);
      op = OP_POP_SKIP;
      if (s) start_b = 1'b1;
      else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
    end
    wait (!active);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; op = OP_PUSH;
    pc_a = '0; pc_b = '0; sp_in = '0; x_in = '0; imm = '0; sel = 1'b0;
    a_rdata = '0; b_rdata = '0;
    for (int i = 0; i < 4096; i++) begin
      ram_a[12'(i)] = 4'h0;
      ram_b[12'(i)] = 4'h0;
    end
    #12;
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_pc", a_pc, 0);
    check("rst_sp", a_sp, 0);
    check("rst_x", a_x, 0);
    check("rst_wrap", a_wrap, 0);
    check("rst_we_re", {a_we, a_re}, 0);
    check("rst_addr", a_addr, 0);
    check("rst_b_pc", b_pc, 0);
    check("rst_b_busy", b_busy, 0);
    @(negedge clk);
    reset = 1'b0;

    ram_a[12'h044] = 4'hD; ram_a[12'h045] = 4'h4; ram_a[12'h046] = 4'h7;
    ram_a[12'h050] = 4'hF; ram_a[12'h051] = 4'hF; ram_a[12'h052] = 4'hF;

    run(1'b0, OP_POP, 16'h0000, 8'h44, 12'h000, 8'h00, 0);
    check("pop_pc", a_pc, 13'h074D);
    check("pop_sp", a_sp, 8'h47);
    check("pop_wrap", a_wrap, 0);
    check("pop_done_edge", done_edge, 5);

    run(1'b0, OP_POP_SKIP, 16'h0000, 8'h44, 12'h000, 8'h00, 0);
    check("skip_pc", a_pc, 13'h074E);
    check("skip_sp", a_sp, 8'h47);
    check("skip_done_edge", done_edge, 6);

    run(1'b0, OP_POP_SKIP, 16'h1000, 8'h50, 12'h000, 8'h00, 0);
    check("skip_carry_pc", a_pc, 13'h1000);

    run(1'b0, OP_POP_DATA, 16'h0000, 8'h44, 12'h4F1, 8'hFC, 0);
    check("data_ram0", ram_a[12'h4F1], 4'hC);
    check("data_ram1", ram_a[12'h4F2], 4'hF);
    check("data_x", a_x, 12'h4F3);
    check("data_pc", a_pc, 13'h074D);
    check("data_done_edge", done_edge, 7);

    run(1'b0, OP_POP_DATA, 16'h0000, 8'h44, 12'h4FF, 8'hFC, 0);
    check("data_wrap_ram0", ram_a[12'h4FF], 4'hC);
    check("data_wrap_ram1", ram_a[12'h400], 4'hF);
    check("data_wrap_x", a_x, 12'h401);

    run(1'b0, OP_PUSH, 16'h1A3C, 8'h02, 12'h000, 8'h00, 0);
    check("push_ram01", ram_a[12'h001], 4'hA);
    check("push_ram00", ram_a[12'h000], 4'h3);
    check("push_ramff", ram_a[12'h0FF], 4'hC);
    check("push_sp", a_sp, 8'hFF);
    check("push_wrap", a_wrap, 1);
    check("push_pc", a_pc, 13'h1A3C);
    check("push_done_edge", done_edge, 4);

    run(1'b0, OP_POP, 16'h0000, 8'hFE, 12'h000, 8'h00, 0);
    check("popwrap_pc", a_pc, 13'h03C0);
    check("popwrap_sp", a_sp, 8'h01);
    check("popwrap_wrap", a_wrap, 1);

    // Reset lands mid-push: only the first nibble may reach RAM
    @(negedge clk);
    sel = 1'b0; op = OP_PUSH; pc_a = 13'h0ABC; sp_in = 8'h30; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_we", a_we, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_done", a_done, 0);
    check("midrst_pc", a_pc, 0);
    check("midrst_sp", a_sp, 0);
    check("midrst_addr", a_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_ram2f", ram_a[12'h02F], 4'hA);
    check("midrst_ram2e", ram_a[12'h02E], 4'h0);
    check("midrst_ram2d", ram_a[12'h02D], 4'h0);

    run(1'b0, OP_POP, 16'h0000, 8'h44, 12'h000, 8'h00, 0);
    check("after_rst_pc", a_pc, 13'h074D);

    run(1'b1, OP_PUSH, 16'hBEEF, 8'h80, 12'h000, 8'h00, 2);
    check("b_push_ram7f", ram_b[12'h07F], 4'hB);
    check("b_push_ram7c", ram_b[12'h07C], 4'hF);
    check("b_push_sp", b_sp, 8'h7C);
    check("b_push_done_edge", done_edge, 5);

    run(1'b1, OP_POP, 16'h0000, 8'h7C, 12'h000, 8'h00, 3);
    check("b_pop_pc", b_pc, 16'hBEEF);
    check("b_pop_sp", b_sp, 8'h80);
    check("b_pop_done_edge", done_edge, 6);

    repeat (3) @(negedge clk);
    check("b_idle_busy", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
